mem_access_unit: RTL

Load/store front end for the RV32I data memory: accepts one byte-addressed load or store request at a time from the execute stage and drives the word-addressed simple-dual-port RAM driver directly downstream. The RAM has no byte enables, so sub-word stores are performed as read-modify-write. Load data is returned with RV32I sign or zero extension. Misaligned, out-of-range and illegal-width accesses are rejected without touching memory.

---
 rtl/mem_access_unit_if.sv | 39 +++
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and RAM-driver signal bundle for mem_access_unit.
// Signal prefixes are from the unit's point of view (i_ = into the unit).
interface mem_access_unit_if #(
  parameter int DLEN = 32,
  parameter int ALEN = 10
) ();
  logic            i_req_valid;
  logic            o_req_ready;
  logic            i_req_we;
  logic [2:0]      i_req_funct3;
  logic [31:0]     i_req_addr;
  logic [31:0]     i_req_wdata;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [31:0]     o_rsp_rdata;
  logic            o_rsp_err;
  logic            o_mem_wvalid;
  logic [ALEN-1:0] o_mem_waddr;
  logic [DLEN-1:0] o_mem_wdata;
  logic            o_mem_rvalid;
  logic [ALEN-1:0] o_mem_raddr;
  logic [DLEN-1:0] i_mem_rdata;

  // The load/store unit itself.
  modport slave (
    input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
    input  i_rsp_ready, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_mem_wvalid, o_mem_waddr, o_mem_wdata, o_mem_rvalid, o_mem_raddr
  );

  // Execute stage plus RAM driver, seen from outside the unit.
  modport master (
    output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
    output i_rsp_ready, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_mem_wvalid, o_mem_waddr, o_mem_wdata, o_mem_rvalid, o_mem_raddr
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store front end for a word-addressed RAM without byte enables.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
module mem_access_unit #(
  parameter int BLEN = 8,
  parameter int WLEN = 4,
  parameter int DLEN = BLEN * WLEN,
  parameter int MLEN = 1024,
  parameter int ALEN = $clog2(MLEN)
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);
  localparam int LLEN = $clog2(WLEN);
  localparam logic [DLEN-1:0] ByteMask = DLEN'({BLEN{1'b1}});
  localparam logic [DLEN-1:0] HalfMask = DLEN'({(2 * BLEN){1'b1}});

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StRsp} state_e;

  state_e          r_state;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [ALEN-1:0] r_word_addr;
  logic [LLEN-1:0] r_lane;
  logic [31:0]     r_wdata;
  logic            r_rsp_valid;
  logic            r_rsp_err;
  logic [31:0]     r_rsp_rdata;
  logic            r_mem_wvalid;
  logic            r_mem_rvalid;
  logic [DLEN-1:0] r_mem_wdata;

  logic            w_accept;
  logic            w_f3_legal;
  logic            w_misaligned;
  logic            w_out_of_range;
  logic            w_req_err;
  logic            w_req_sw;
  int unsigned     w_byte_sh;
  int unsigned     w_half_sh;
  logic [BLEN-1:0]   w_byte;
  logic [2*BLEN-1:0] w_half;
  logic [DLEN-1:0] w_load;
  logic [DLEN-1:0] w_mask;
  logic [DLEN-1:0] w_ins;
  logic [DLEN-1:0] w_merged;

  assign w_accept = bus.i_req_valid && (r_state == StIdle);
  assign w_req_sw = bus.i_req_we && (bus.i_req_funct3 == 3'b010);

  // Classify the incoming request; illegal ones never reach the RAM.
  always_comb begin
    w_f3_legal = 1'b0;
    case (bus.i_req_funct3)
      3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
      3'b100, 3'b101:         w_f3_legal = !bus.i_req_we;  // no unsigned stores
      default:                w_f3_legal = 1'b0;
    endcase
    w_misaligned = ((bus.i_req_funct3[1:0] == 2'b01) && bus.i_req_addr[0]) ||
                   ((bus.i_req_funct3[1:0] == 2'b10) && (bus.i_req_addr[LLEN-1:0] != '0));
    w_out_of_range = |bus.i_req_addr[31:ALEN+LLEN];
    w_req_err = !w_f3_legal || w_misaligned || w_out_of_range;
  end

  assign w_byte_sh = BLEN * 32'(r_lane);
  assign w_half_sh = 2 * BLEN * 32'(r_lane[LLEN-1]);
  assign w_byte    = bus.i_mem_rdata[w_byte_sh +: BLEN];
  assign w_half    = bus.i_mem_rdata[w_half_sh +: 2 * BLEN];

  // Lane extraction and extension of the RAM word for loads.
  always_comb begin
    w_load = bus.i_mem_rdata;
    case (r_funct3)
      3'b000:  w_load = {{(DLEN - BLEN){w_byte[BLEN-1]}}, w_byte};
      3'b001:  w_load = {{(DLEN - 2 * BLEN){w_half[2*BLEN-1]}}, w_half};
      3'b100:  w_load = {{(DLEN - BLEN){1'b0}}, w_byte};
      3'b101:  w_load = {{(DLEN - 2 * BLEN){1'b0}}, w_half};
      default: w_load = bus.i_mem_rdata;
    endcase
  end

  // Merge store data into the word read back (SB: funct3[0]=0, SH: funct3[0]=1).
  always_comb begin
    if (r_funct3[0]) begin
      w_mask = HalfMask << w_half_sh;
      w_ins  = (r_wdata & HalfMask) << w_half_sh;
    end else begin
      w_mask = ByteMask << w_byte_sh;
      w_ins  = (r_wdata & ByteMask) << w_byte_sh;
    end
    w_merged = (bus.i_mem_rdata & ~w_mask) | w_ins;
  end

  // Sequencer: every output is registered here and only decoded from state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_word_addr  <= '0;
      r_lane       <= '0;
      r_wdata      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= '0;
      r_mem_wvalid <= 1'b0;
      r_mem_rvalid <= 1'b0;
      r_mem_wdata  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_we        <= bus.i_req_we;
            r_funct3    <= bus.i_req_funct3;
            r_word_addr <= bus.i_req_addr[ALEN+LLEN-1:LLEN];
            r_lane      <= bus.i_req_addr[LLEN-1:0];
            r_wdata     <= bus.i_req_wdata;
            if (w_req_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_state     <= StRsp;
            end else if (w_req_sw) begin
              r_mem_wdata  <= bus.i_req_wdata;
              r_mem_wvalid <= 1'b1;
              r_state      <= StWr;
            end else begin
              r_mem_rvalid <= 1'b1;
              r_state      <= StRd;
            end
          end
        end
        StRd: begin
          r_mem_rvalid <= 1'b0;
          r_state      <= StCap;
        end
        StCap: begin
          if (r_we) begin
            r_mem_wdata  <= w_merged;
            r_mem_wvalid <= 1'b1;
            r_state      <= StWr;
          end else begin
            r_rsp_rdata <= w_load;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= StRsp;
          end
        end
        StWr: begin
          r_mem_wvalid <= 1'b0;
          r_rsp_rdata  <= '0;
          r_rsp_err    <= 1'b0;
          r_rsp_valid  <= 1'b1;
          r_state      <= StRsp;
        end
        StRsp: begin
          if (bus.i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outputs are forced low during reset so a WR cycle hit by rst never writes.
  assign bus.o_req_ready  = (r_state == StIdle) && !rst;
  assign bus.o_rsp_valid  = r_rsp_valid && !rst;
  assign bus.o_rsp_err    = r_rsp_err && !rst;
  assign bus.o_rsp_rdata  = rst ? '0 : r_rsp_rdata;
  assign bus.o_mem_wvalid = r_mem_wvalid && !rst;
  assign bus.o_mem_rvalid = r_mem_rvalid && !rst;
  assign bus.o_mem_waddr  = rst ? '0 : r_word_addr;
  assign bus.o_mem_raddr  = rst ? '0 : r_word_addr;
  assign bus.o_mem_wdata  = rst ? '0 : r_mem_wdata;

endmodule
